// File: rtl/psum_pkt_pkg.sv
// Shared definitions for the adder-to-memory psum packet path: default widths,
// node addresses, packet field offsets and the packet layout.
package psum_pkt_pkg;

  localparam int unsigned PSUM_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;

  localparam logic [ADDR_W_DEF-1:0] MEM_ADDR   = 4'b1000;
  localparam logic [ADDR_W_DEF-1:0] ADDER_ADDR = 4'b0010;

  // Field offsets within the packet, LSB first: dest, src, psum, spike.
  localparam int unsigned DEST_LSB  = 0;
  localparam int unsigned SRC_LSB   = ADDR_W_DEF;
  localparam int unsigned PSUM_LSB  = 2 * ADDR_W_DEF;
  localparam int unsigned SPIKE_BIT = PSUM_LSB + PSUM_W_DEF;
  localparam int unsigned PKT_W_DEF = SPIKE_BIT + 1;

  typedef struct packed {
    logic                  spike;
    logic [PSUM_W_DEF-1:0] psum;
    logic [ADDR_W_DEF-1:0] src;
    logic [ADDR_W_DEF-1:0] dest;
  } psum_pkt_t;

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous packet FIFO with occupancy output. Push and pop in the same
// cycle are legal at any level, including full, provided the caller gates push.
module pkt_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [LvlW-1:0]  level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_i) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop_i) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage is cleared on reset so the head reads back as zero after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= wdata_i;
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LvlW'(Depth));
  assign level_o = level_q;

endmodule

// File: rtl/psum_packet_encoder.sv
// Multi-lane psum packet encoder: round-robin arbitration over adder lanes,
// psum saturation, address stamping and an output FIFO toward the NoC router.
module psum_packet_encoder
  import psum_pkt_pkg::*;
#(
  parameter int unsigned       N_CH      = 4,
  parameter int unsigned       IN_W      = 10,
  parameter int unsigned       PSUM_W    = PSUM_W_DEF,
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] SRC_BASE  = ADDR_W'(ADDER_ADDR),
  parameter logic [ADDR_W-1:0] DEST_ADDR = ADDR_W'(MEM_ADDR),
  parameter int unsigned       DEPTH     = 4,
  localparam int unsigned      PKT_W     = 1 + PSUM_W + 2 * ADDR_W,
  localparam int unsigned      LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [N_CH-1:0]      in_valid_i,
  output logic [N_CH-1:0]      in_ready_o,
  input  logic [N_CH-1:0]      in_spike_i,
  input  logic [N_CH*IN_W-1:0] in_psum_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PKT_W-1:0]     out_packet_o,
  output logic [15:0]          pkt_count_o,
  output logic [LVL_W-1:0]     fifo_level_o
);

  localparam int unsigned RR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IN_W-1:0] PSUM_MAX = IN_W'((64'd1 << PSUM_W) - 64'd1);

  logic [RR_W-1:0]   rr_q, rr_d;
  logic [RR_W-1:0]   grant;
  logic              found;
  logic              space;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IN_W-1:0]   lane_psum;
  logic [PSUM_W-1:0] psum_field;
  logic [PKT_W-1:0]  pkt;
  logic [15:0]       pkt_count_q, pkt_count_d;

  // First valid lane at or after rr, wrapping around.
  always_comb begin : p_arb
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = (32'(rr_q) + k) % N_CH;
      if (!found && in_valid_i[idx]) begin
        found = 1'b1;
        grant = RR_W'(idx);
      end
    end
  end

  // A pop this cycle frees a slot, so a full FIFO can still accept.
  assign pop    = out_valid_o && out_ready_i;
  assign space  = !fifo_full || pop;
  assign accept = found && space;

  always_comb begin
    in_ready_o = '0;
    if (accept) begin
      in_ready_o[grant] = 1'b1;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (32'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
    end
  end

  assign lane_psum  = in_psum_i[32'(grant)*IN_W +: IN_W];
  assign psum_field = (lane_psum > PSUM_MAX) ? '1 : lane_psum[PSUM_W-1:0];
  assign pkt        = {in_spike_i[grant], psum_field, SRC_BASE + ADDR_W'(grant), DEST_ADDR};

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (pop) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_q        <= '0;
      pkt_count_q <= '0;
    end else begin
      rr_q        <= rr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  pkt_fifo #(
    .Width (PKT_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (accept),
    .wdata_i (pkt),
    .pop_i   (pop),
    .rdata_o (out_packet_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level_o)
  );

  assign out_valid_o = !fifo_empty;
  assign pkt_count_o = pkt_count_q;

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(in_ready_o));
  a_level_bound: assert property (@(posedge clk_i) disable iff (reset_i)
    fifo_level_o <= LVL_W'(DEPTH));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (fifo_full && !pop) |-> (in_ready_o == '0));

endmodule

// File: tb/tb_psum_packet_encoder.sv
// Directed-vector bench for psum_packet_encoder with default parameters.
module tb_psum_packet_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  in_spike;
  logic [39:0] in_psum;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_packet;
  logic [15:0] pkt_count;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psum_packet_encoder dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_spike_i   (in_spike),
    .in_psum_i    (in_psum),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_packet_o (out_packet),
    .pkt_count_o  (pkt_count),
    .fifo_level_o (fifo_level)
  );

  function automatic logic [16:0] mk(input logic s, input logic [7:0] p, input logic [3:0] src);
    return {s, p, src, 4'b1000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = '0;
    in_spike  = '0;
    in_psum   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = '0;
    in_spike  = '0;
    in_psum   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level);
    end
    checks++;
    if (pkt_count !== 16'd0) begin
      errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count);
    end
    checks++;
    if (out_packet !== 17'h0) begin
      errors++; $display("FAIL reset_out_packet: got %h expected 0", out_packet);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_lane();
    in_valid      = 4'b0001;
    in_spike      = 4'b0001;
    in_psum[9:0]  = 10'd37;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL single_in_ready: got %b expected 0001", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_no_bypass: got %b expected 0", out_valid);
    end
    step();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_packet !== 17'h12528) begin
      errors++;
      $display("FAIL single_packet: got v=%b %h expected v=1 12528", out_valid, out_packet);
    end
    checks++;
    if (fifo_level !== 3'd1) begin
      errors++; $display("FAIL single_level: got %0d expected 1", fifo_level);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (pkt_count !== 16'd1 || out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: got cnt=%0d v=%b lvl=%0d expected 1 0 0",
               pkt_count, out_valid, fifo_level);
    end
  endtask

  task automatic test_round_robin();
    logic [16:0] exp_pkt [4];
    exp_pkt[0] = mk(1'b0, 8'd11, 4'd2);
    exp_pkt[1] = mk(1'b1, 8'd21, 4'd3);
    exp_pkt[2] = mk(1'b0, 8'd31, 4'd4);
    exp_pkt[3] = mk(1'b1, 8'd41, 4'd5);
    apply_reset();
    in_valid  = 4'b1111;
    in_spike  = 4'b1010;
    in_psum   = {10'd41, 10'd31, 10'd21, 10'd11};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready !== (4'b0001 << (k % 4))) begin
        errors++;
        $display("FAIL rr_grant_%0d: got %b expected %b", k, in_ready, 4'b0001 << (k % 4));
      end
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_packet !== exp_pkt[(k-1)%4] || fifo_level !== 3'd1) begin
          errors++;
          $display("FAIL rr_packet_%0d: got v=%b %h lvl=%0d expected v=1 %h lvl=1",
                   k, out_valid, out_packet, fifo_level, exp_pkt[(k-1)%4]);
        end
      end
      step();
    end
    in_valid = '0;
    checks++;
    if (out_packet !== exp_pkt[0] || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL rr_fifth: got %h lvl=%0d expected %h lvl=1", out_packet, fifo_level, exp_pkt[0]);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (pkt_count !== 16'd5 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL rr_count: got cnt=%0d lvl=%0d expected 5 0", pkt_count, fifo_level);
    end
  endtask

  task automatic test_saturation();
    int          lanes [4];
    int          vals  [4];
    logic [16:0] exp_pkt [4];
    lanes = '{1, 2, 3, 0};
    vals  = '{700, 255, 256, 254};
    exp_pkt[0] = mk(1'b0, 8'd255, 4'd3);
    exp_pkt[1] = mk(1'b0, 8'd255, 4'd4);
    exp_pkt[2] = mk(1'b1, 8'd255, 4'd5);
    exp_pkt[3] = mk(1'b0, 8'd254, 4'd2);
    for (int v = 0; v < 4; v++) begin
      in_valid = '0;
      in_spike = '0;
      in_valid[lanes[v]] = 1'b1;
      in_spike[lanes[v]] = (v == 2);
      in_psum[lanes[v]*10 +: 10] = 10'(vals[v]);
      out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== (4'b0001 << lanes[v])) begin
        errors++;
        $display("FAIL sat_grant_%0d: got %b expected %b", v, in_ready, 4'b0001 << lanes[v]);
      end
      step();
      in_valid = '0;
      checks++;
      if (out_packet !== exp_pkt[v]) begin
        errors++;
        $display("FAIL sat_packet_%0d: got %h expected %h", v, out_packet, exp_pkt[v]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] drain [4];
    drain[0] = mk(1'b0, 8'd101, 4'd3);
    drain[1] = mk(1'b0, 8'd102, 4'd4);
    drain[2] = mk(1'b0, 8'd103, 4'd5);
    drain[3] = mk(1'b0, 8'd104, 4'd2);
    apply_reset();
    in_valid = 4'b1111;
    in_spike = '0;
    in_psum  = {10'd103, 10'd102, 10'd101, 10'd100};
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (in_ready !== (4'b0001 << k)) begin
        errors++; $display("FAIL bp_fill_%0d: got %b expected %b", k, in_ready, 4'b0001 << k);
      end
      step();
      if (k == 0) in_psum[9:0] = 10'd104;
      else        in_valid[k] = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000 || fifo_level !== 3'd4 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_full_%0d: got rdy=%b lvl=%0d v=%b expected 0000 4 1",
                 k, in_ready, fifo_level, out_valid);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001 || out_packet !== mk(1'b0, 8'd100, 4'd2)) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b %h expected 0001 %h",
               in_ready, out_packet, mk(1'b0, 8'd100, 4'd2));
    end
    step();
    in_valid = '0;
    checks++;
    if (fifo_level !== 3'd4) begin
      errors++; $display("FAIL bp_level_hold: got %0d expected 4", fifo_level);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (out_packet !== drain[j]) begin
        errors++; $display("FAIL bp_drain_%0d: got %h expected %h", j, out_packet, drain[j]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd0 || pkt_count !== 16'd5) begin
      errors++;
      $display("FAIL bp_end: got lvl=%0d cnt=%0d expected 0 5", fifo_level, pkt_count);
    end
  endtask

  task automatic test_full_push_pop();
    logic [16:0] q [$];
    logic [16:0] head;
    int          exp_lvl;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 4'b0100;
      in_spike = '0;
      in_spike[2] = i[0];
      in_psum[29:20] = 10'(200 + i);
      out_ready = (i >= 4);
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
        errors++; $display("FAIL fpp_ready_%0d: got %b expected 0100", i, in_ready);
      end
      if (out_ready) begin
        head = q.pop_front();
        checks++;
        if (out_packet !== head) begin
          errors++; $display("FAIL fpp_head_%0d: got %h expected %h", i, out_packet, head);
        end
      end
      q.push_back(mk(i[0], 8'(200 + i), 4'd4));
      step();
      exp_lvl = (i < 4) ? i + 1 : 4;
      checks++;
      if (fifo_level !== 3'(exp_lvl)) begin
        errors++; $display("FAIL fpp_level_%0d: got %0d expected %0d", i, fifo_level, exp_lvl);
      end
    end
    in_valid  = '0;
    out_ready = 1'b1;
    while (q.size() > 0) begin
      head = q.pop_front();
      checks++;
      if (out_packet !== head || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL fpp_drain: got v=%b %h expected v=1 %h", out_valid, out_packet, head);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd0 || pkt_count !== 16'd10) begin
      errors++;
      $display("FAIL fpp_end: got lvl=%0d cnt=%0d expected 0 10", fifo_level, pkt_count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    in_valid = 4'b0010;
    in_spike = '0;
    for (int i = 0; i < 4; i++) begin
      in_psum[19:10] = 10'(50 + i);
      step();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd3 || pkt_count !== 16'd1) begin
      errors++;
      $display("FAIL mid_setup: got lvl=%0d cnt=%0d expected 3 1", fifo_level, pkt_count);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_flush: got v=%b lvl=%0d cnt=%0d expected 0 0 0",
               out_valid, fifo_level, pkt_count);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    in_valid = 4'b1111;
    in_psum  = {10'd4, 10'd3, 10'd2, 10'd1};
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_rr_reset: got %b expected 0001", in_ready);
    end
    step();
    in_valid = '0;
    checks++;
    if (out_packet !== mk(1'b0, 8'd1, 4'd2)) begin
      errors++;
      $display("FAIL mid_first_pkt: got %h expected %h", out_packet, mk(1'b0, 8'd1, 4'd2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_lane();
    test_round_robin();
    test_saturation();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psum_packet_encoder.md
# psum_packet_encoder

Clocked, multi-channel successor to the single-adder packet encoder on the adder-to-memory path. It accepts partial-sum/spike results from N_CH adder lanes over valid/ready handshakes and arbitrates among them round-robin. It saturates each psum into the packet field, stamps per-lane source and fixed destination addresses, and queues finished packets in an output FIFO toward the NoC router port. It adds multi-lane arbitration, buffering, saturation and a packet counter, none of which the single-lane encoder has.

## Interface
- N_CH, 4: number of adder lanes (1..8)
- IN_W, 10: width of each incoming psum (IN_W >= PSUM_W)
- PSUM_W, 8: psum field width in the packet
- ADDR_W, 4: source/destination address width
- SRC_BASE, 4'b0010: source address of lane 0; lane i uses SRC_BASE+i (mod 2^ADDR_W)
- DEST_ADDR, 4'b1000: destination (memory node) stamped on every packet
- DEPTH, 4: output FIFO entries (power of two, >= 2)
- PKT_W, derived: 1+PSUM_W+2*ADDR_W (17 by default)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  N_CH  lane i holds a result
- in_ready  out  N_CH  lane i result accepted this edge when in_valid[i] is also 1
- in_spike  in  N_CH  spike bit per lane
- in_psum  in  N_CH*IN_W  lane i psum at bits [i*IN_W +: IN_W], unsigned
- out_valid  out  1  FIFO head valid
- out_ready  in  1  router consumes head
- out_packet  out  PKT_W  {spike, psum, src, dest}, MSB first
- pkt_count  out  16  packets popped since reset, wraps at 2^16
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Arbitration: grant = first lane with in_valid set, searching from pointer rr. in_ready is one-hot on grant only, and is asserted only when space is available (space = !full || (out_valid && out_ready)). The arbiter grants at most one lane per cycle.
- On acceptance of lane g, rr becomes (g+1) mod N_CH. rr is unchanged when nothing is accepted. rr = 0 after reset.
- Packet build: psum field = in_psum[g] if it is < 2^PSUM_W, else all ones (saturate). spike = in_spike[g]. src = SRC_BASE+g. dest = DEST_ADDR.
- FIFO: write on acceptance, read on out_valid && out_ready. Simultaneous push and pop is legal at any level, including full; occupancy is then unchanged.
- When empty, out_valid=0 and out_packet holds its last value (don't-care). The block does no bypass.
- pkt_count increments on each pop.
- Inputs must hold stable while in_valid=1 and in_ready=0. Lanes may deassert in_valid before being granted; the block drops no accepted data.

## Timing
- Reset values: in_ready=0, out_valid=0, out_packet=0, pkt_count=0, fifo_level=0, rr=0. FIFO pointers clear.
- Reset asserted mid-operation flushes the FIFO immediately. A packet on the output that has not been handshaked is lost.
- in_ready is combinational from in_valid, rr, full, out_valid and out_ready. No other combinational path from inputs to outputs exists.
- Latency: a packet accepted at edge k is presented with out_valid=1 after edge k. It can be popped at edge k+1 at the earliest.
- Throughput: one packet per cycle sustained when out_ready=1.
- Full (level=DEPTH) with out_ready=0: all in_ready=0 and rr holds.

## Structure
- Shared package psum_pkt_pkg holds: PSUM_W/ADDR_W defaults, MEM_ADDR=4'b1000, ADDER_ADDR=4'b0010, packet field offset constants, and a packed struct psum_pkt_t {spike, psum, src, dest}.
- Sub-module pkt_fifo (parametrised width/depth synchronous FIFO with level output). The arbiter, saturation logic and counter live in the top module.

## Test plan
- Single lane: lane 0 sends psum=37, spike=1. Expect out_packet = {1, 8'd37, 4'b0010, 4'b1000} after 1 cycle, then pkt_count=1.
- All four lanes are valid continuously with out_ready=1. Expect grants in order 0,1,2,3,0 and src fields 2,3,4,5,2, at one packet per cycle.
- Saturation: IN_W=10 with psum=700 → psum field 255. psum=255 → 255. psum=256 → 255.
- Backpressure: out_ready=0 while 5 results are offered with DEPTH=4. Expect level=4, all in_ready=0 and rr frozen. When out_ready=1, packets drain in order and the 5th is accepted on the first pop cycle.
- Full plus simultaneous pop and push: expect level to stay at 4 and no data loss or duplication, checked against a scoreboard.
- Assert reset with 3 packets queued: expect out_valid=0 and level=0 immediately. pkt_count=0. The next accepted packet is granted from lane 0 first.
